// File: rtl/collision_scanner.sv
// collision_scanner
// Holds a small table of axis-aligned boxes. On each start pulse it walks every
// unordered pair (i, j), i < j, in lexicographic order, presents the pair to an
// external combinational overlap checker, and hands each colliding pair of
// active boxes to a valid/ready consumer. It also accumulates a per-object
// collision mask for the scan.

module collision_scanner #(
    parameter int POSITION_REG_MAX = 11,
    parameter int NUM_OBJ          = 8,
    localparam int IW              = $clog2(NUM_OBJ),
    localparam int PW              = POSITION_REG_MAX + 1
) (
    input  logic               clk,
    input  logic               rst_n,

    // Table write port
    input  logic               wr_en,
    input  logic [IW-1:0]      wr_idx,
    input  logic               wr_active,
    input  logic [PW-1:0]      wr_x1,
    input  logic [PW-1:0]      wr_y1,
    input  logic [PW-1:0]      wr_x2,
    input  logic [PW-1:0]      wr_y2,

    // Scan control
    input  logic               start,
    output logic               busy,
    output logic               done,

    // Pair presented to the external overlap checker
    output logic [PW-1:0]      box1_x1,
    output logic [PW-1:0]      box1_y1,
    output logic [PW-1:0]      box1_x2,
    output logic [PW-1:0]      box1_y2,
    output logic [PW-1:0]      box2_x1,
    output logic [PW-1:0]      box2_y1,
    output logic [PW-1:0]      box2_x2,
    output logic [PW-1:0]      box2_y2,
    input  logic               overlap,

    // Colliding-pair report
    output logic               pair_valid,
    input  logic               pair_ready,
    output logic [IW-1:0]      pair_a,
    output logic [IW-1:0]      pair_b,
    output logic [NUM_OBJ-1:0] collide_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REPORT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic          active;
        logic [PW-1:0] x1;
        logic [PW-1:0] y1;
        logic [PW-1:0] x2;
        logic [PW-1:0] y2;
    } entry_t;

    // The pair (LAST_I, LAST_J) is the final one of every scan.
    localparam logic [IW-1:0] LAST_I = IW'(NUM_OBJ - 2);
    localparam logic [IW-1:0] LAST_J = IW'(NUM_OBJ - 1);
    localparam logic [IW-1:0] ONE    = IW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    entry_t        obj_tab [NUM_OBJ];

    logic          hit;
    logic          last_pair;
    logic          launch;
    logic          take_hit;
    logic          advance;
    logic [IW-1:0] i_inc;

    assign busy       = (state_q == S_SCAN) || (state_q == S_REPORT);
    assign done       = (state_q == S_DONE);
    assign pair_valid = (state_q == S_REPORT);

    assign hit       = overlap & obj_tab[i_q].active & obj_tab[j_q].active;
    assign last_pair = (i_q == LAST_I) && (j_q == LAST_J);
    assign i_inc     = i_q + ONE;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle control strobes.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        take_hit = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hit) begin
                    take_hit = 1'b1;
                    state_d  = S_REPORT;
                end else begin
                    advance = 1'b1;
                    state_d = last_pair ? S_DONE : S_SCAN;
                end
            end
            S_REPORT: begin
                if (pair_ready) begin
                    advance = 1'b1;
                    state_d = last_pair ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pair walk: j runs to the end of the table, then i steps and j restarts
    // just above it. The final pair is never stepped past.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= ONE;
        end else if (launch) begin
            i_q <= '0;
            j_q <= ONE;
        end else if (advance && !last_pair) begin
            if (j_q != LAST_J) begin
                j_q <= j_q + ONE;
            end else begin
                i_q <= i_inc;
                j_q <= i_inc + ONE;
            end
        end
    end

    // Capture each colliding pair and accumulate the per-object mask; the mask
    // is only cleared by the next accepted start so it survives DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_a       <= '0;
            pair_b       <= '0;
            collide_mask <= '0;
        end else if (launch) begin
            collide_mask <= '0;
        end else if (take_hit) begin
            pair_a            <= i_q;
            pair_b            <= j_q;
            collide_mask[i_q] <= 1'b1;
            collide_mask[j_q] <= 1'b1;
        end
    end

    // Object table; writes are dropped while a scan is walking it.
    // NOTE: the table is a register array with an async reset, not a RAM,
    // because every entry must read back inactive and zeroed after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OBJ; k++) begin
                obj_tab[k] <= '0;
            end
        end else if (wr_en && !busy) begin
            obj_tab[wr_idx] <= '{active: wr_active,
                                 x1: wr_x1, y1: wr_y1,
                                 x2: wr_x2, y2: wr_y2};
        end
    end

    // Present the current pair to the checker only while scanning/reporting.
    always_comb begin
        box1_x1 = '0;
        box1_y1 = '0;
        box1_x2 = '0;
        box1_y2 = '0;
        box2_x1 = '0;
        box2_y1 = '0;
        box2_x2 = '0;
        box2_y2 = '0;
        if (busy) begin
            box1_x1 = obj_tab[i_q].x1;
            box1_y1 = obj_tab[i_q].y1;
            box1_x2 = obj_tab[i_q].x2;
            box1_y2 = obj_tab[i_q].y2;
            box2_x1 = obj_tab[j_q].x1;
            box2_y1 = obj_tab[j_q].y1;
            box2_x2 = obj_tab[j_q].x2;
            box2_y2 = obj_tab[j_q].y2;
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: fills the table, runs scans with a
// behavioural strict-overlap checker and a scripted consumer, and compares
// latency, reported pairs and the collision mask with hand-computed values.

module tb_collision_scanner;

    localparam int PW = 12;
    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          wr_active;
    logic [PW-1:0] wr_x1, wr_y1, wr_x2, wr_y2;
    logic          start;
    logic          busy, done;
    logic [PW-1:0] box1_x1, box1_y1, box1_x2, box1_y2;
    logic [PW-1:0] box2_x1, box2_y1, box2_x2, box2_y2;
    logic          overlap;
    logic          pair_valid, pair_ready;
    logic [IW-1:0] pair_a, pair_b;
    logic [N-1:0]  collide_mask;

    int checks   = 0;
    int failures = 0;

    // Results captured by run_scan
    int r_done_cyc, r_busy_cnt, r_pv_cnt, r_a, r_b, r_stab_err;
    int r_busy_at_done, r_bx1, r_bx2;

    collision_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_active    (wr_active),
        .wr_x1        (wr_x1),
        .wr_y1        (wr_y1),
        .wr_x2        (wr_x2),
        .wr_y2        (wr_y2),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .box1_x1      (box1_x1),
        .box1_y1      (box1_y1),
        .box1_x2      (box1_x2),
        .box1_y2      (box1_y2),
        .box2_x1      (box2_x1),
        .box2_y1      (box2_y1),
        .box2_x2      (box2_x2),
        .box2_y2      (box2_y2),
        .overlap      (overlap),
        .pair_valid   (pair_valid),
        .pair_ready   (pair_ready),
        .pair_a       (pair_a),
        .pair_b       (pair_b),
        .collide_mask (collide_mask)
    );

    always #5 clk = ~clk;

    // Behavioural checker: strict overlap, so shared edges do not collide.
    assign overlap = (box1_x1 < box2_x2) && (box2_x1 < box1_x2) &&
                     (box1_y1 < box2_y2) && (box2_y1 < box1_y2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic write_entry(input int idx, input logic act,
                               input int x1, input int y1, input int x2, input int y2);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_idx    = IW'(idx);
        wr_active = act;
        wr_x1     = PW'(x1);
        wr_y1     = PW'(y1);
        wr_x2     = PW'(x2);
        wr_y2     = PW'(y2);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulse start, then observe each cycle at the falling edge. Cycle 0 is the
    // cycle whose rising edge samples start. The consumer holds pair_ready low
    // for `delay` valid cycles, then raises it. With `disturb` set, a write to
    // entry 2 and a second start are issued mid-scan.
    task automatic run_scan(input int delay, input bit disturb);
        r_done_cyc = -1; r_busy_cnt = 0; r_pv_cnt = 0; r_a = -1; r_b = -1;
        r_stab_err = 0; r_busy_at_done = -1; r_bx1 = -1; r_bx2 = -1;
        @(negedge clk);
        start      = 1'b1;
        pair_ready = (delay == 0);
        @(posedge clk);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == 3) begin
                r_bx1 = int'(box1_x2);
                r_bx2 = int'(box2_x1);
            end
            if (disturb && cyc == 3) begin
                wr_en = 1'b1; wr_idx = 3'd2; wr_active = 1'b1;
                wr_x1 = 12'd2; wr_y1 = 12'd2; wr_x2 = 12'd8; wr_y2 = 12'd8;
                start = 1'b1;
            end
            if (disturb && cyc == 4) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (busy) r_busy_cnt++;
            if (pair_valid) begin
                if (r_pv_cnt == 0) begin
                    r_a = int'(pair_a);
                    r_b = int'(pair_b);
                end else if (int'(pair_a) != r_a || int'(pair_b) != r_b) begin
                    r_stab_err++;
                end
                pair_ready = (r_pv_cnt >= delay);
                r_pv_cnt++;
            end else begin
                pair_ready = (delay == 0);
            end
            if (done) begin
                r_done_cyc     = cyc;
                r_busy_at_done = int'(busy);
                break;
            end
        end
        pair_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seen_done;
        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_active = 1'b0;
        wr_x1 = '0; wr_y1 = '0; wr_x2 = '0; wr_y2 = '0;
        start = 1'b0; pair_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pair_valid", pair_valid, 0);
        check("rst_pair_ab", {pair_a, pair_b}, 0);
        check("rst_mask", collide_mask, 0);
        check("rst_box", {box1_x1, box2_y2}, 0);
        rst_n = 1'b1;

        // All entries inactive: 28 busy cycles, done in cycle 29
        run_scan(0, 1'b0);
        check("idle_done_cycle", r_done_cyc, 29);
        check("idle_busy_cycles", r_busy_cnt, 28);
        check("idle_busy_at_done", r_busy_at_done, 0);
        check("idle_no_pairs", r_pv_cnt, 0);
        check("idle_mask", collide_mask, 0);

        // Entries 0 and 3 overlap, consumer always ready
        write_entry(0, 1'b1, 0, 0, 10, 10);
        write_entry(3, 1'b1, 5, 5, 15, 15);
        run_scan(0, 1'b0);
        check("hit_done_cycle", r_done_cyc, 30);
        check("hit_pv_cycles", r_pv_cnt, 1);
        check("hit_pair_a", r_a, 0);
        check("hit_pair_b", r_b, 3);
        check("hit_mask", collide_mask, 8'b0000_1001);
        check("hit_box1_x2_cyc3", r_bx1, 10);
        check("hit_box2_x1_cyc3", r_bx2, 5);
        repeat (3) @(negedge clk);
        check("mask_held_idle", collide_mask, 8'b0000_1001);
        check("box_zero_idle", {box1_x2, box2_x1}, 0);
        check("pv_zero_idle", pair_valid, 0);

        // Same pair, consumer stalls for 5 valid cycles
        run_scan(5, 1'b0);
        check("stall_done_cycle", r_done_cyc, 35);
        check("stall_pv_cycles", r_pv_cnt, 6);
        check("stall_pair_stable", r_stab_err, 0);
        check("stall_pair_ab", {r_a[7:0], r_b[7:0]}, 16'h0003);
        check("stall_mask", collide_mask, 8'b0000_1001);

        // Edge-touching boxes do not collide; mask cleared by the new start
        write_entry(3, 1'b0, 5, 5, 15, 15);
        write_entry(1, 1'b1, 10, 0, 20, 10);
        run_scan(0, 1'b0);
        check("touch_no_pairs", r_pv_cnt, 0);
        check("touch_mask", collide_mask, 0);
        check("touch_done_cycle", r_done_cyc, 29);

        // Write and start while busy are dropped; only entry 0 active
        write_entry(1, 1'b0, 10, 0, 20, 10);
        run_scan(0, 1'b1);
        check("busy_start_ignored", r_done_cyc, 29);
        check("busy_write_no_pairs", r_pv_cnt, 0);
        run_scan(0, 1'b0);
        check("busy_write_dropped", r_pv_cnt, 0);
        check("busy_write_mask", collide_mask, 0);

        // Reset while a pair is being reported
        write_entry(3, 1'b1, 5, 5, 15, 15);
        @(negedge clk);
        start = 1'b1;
        pair_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !pair_valid; c++) @(negedge clk);
        check("abort_reached_report", pair_valid, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_pair_valid", pair_valid, 0);
        check("abort_pair_ab", {pair_a, pair_b}, 0);
        check("abort_mask", collide_mask, 0);
        check("abort_box", {box1_x2, box2_x1}, 0);
        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (c == 2) rst_n = 1'b1;
        end
        check("abort_no_done", seen_done, 0);

        // Table was cleared by reset: a fresh scan reports nothing
        run_scan(0, 1'b0);
        check("post_reset_done_cycle", r_done_cyc, 29);
        check("post_reset_no_pairs", r_pv_cnt, 0);
        check("post_reset_mask", collide_mask, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
